// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Used by pc_sequencer and pc_next_calc.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam int PC_INC    = 4;
  localparam int IMM_SHIFT = 2;

endpackage : pc_seq_pkg

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential PC+4 or PC plus word-scaled signed offset.
// Purely combinational; all sums wrap modulo 2^PC_W.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] CurrentPC,
  input  logic [PC_W-1:0] SignExtImm64,
  input  logic            Branch,
  input  logic            Uncondbranch,
  input  logic            ALUZero,
  output logic [PC_W-1:0] NextPC,
  output logic            Taken
);

  logic [PC_W-1:0] w_offset;

  // The shift drops the immediate's top bits; negative offsets still work as two's complement.
  assign w_offset = SignExtImm64 << IMM_SHIFT;
  assign Taken    = Uncondbranch | (Branch & ALUZero);
  assign NextPC   = Taken ? (CurrentPC + w_offset) : (CurrentPC + PC_W'(PC_INC));

endmodule : pc_next_calc

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetch handshake, branch-resolution wait, PC commit, halt.
// Optional saturating retire/taken counters when PC_SEQ_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | one cycle after reset release, no fetch yet
// FETCH  | FetchReq high, waiting for FetchAck
// EXEC   | waiting for BrValid with Stall low, then commit next PC
// HALTED | terminal after a commit with Halt set; only reset exits
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic            CLK,
  input  logic            Reset_L,
  output logic            FetchReq,
  output logic [PC_W-1:0] FetchAddr,
  input  logic            FetchAck,
  input  logic            BrValid,
  input  logic            Branch,
  input  logic            Uncondbranch,
  input  logic            ALUZero,
  input  logic [PC_W-1:0] SignExtImm64,
  input  logic            Stall,
  input  logic            Halt,
  output logic [PC_W-1:0] CurrentPC,
  output logic            Retire,
  output logic            Halted
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [CNT_W-1:0] TakenCnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pc_sequencer: CNT_W must be at least 1");
  end
  if (PC_W <= IMM_SHIFT) begin : g_bad_pc_w
    $error("pc_sequencer: PC_W must exceed the immediate shift");
  end

  seq_state_t      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_req;
  logic            r_retire;
  logic            r_halted;
  logic [PC_W-1:0] w_next_pc;
  logic            w_taken;
  logic            w_commit;

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .CurrentPC    (r_pc),
    .SignExtImm64 (SignExtImm64),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .NextPC       (w_next_pc),
    .Taken        (w_taken)
  );

  assign w_commit = (r_state == EXEC) && BrValid && !Stall;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_fetch_req <= 1'b0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state     <= FETCH;
          r_fetch_req <= 1'b1;
        end
        FETCH: begin
          if (FetchAck) begin
            r_state     <= EXEC;
            r_fetch_req <= 1'b0;
          end
        end
        EXEC: begin
          if (w_commit) begin
            r_pc     <= w_next_pc;
            r_retire <= 1'b1;
            if (Halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state     <= FETCH;
              r_fetch_req <= 1'b1;
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_retire_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_commit) begin
      if (r_retire_cnt != '1) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign RetireCnt = r_retire_cnt;
  assign TakenCnt  = r_taken_cnt;
`endif

  assign FetchReq  = r_fetch_req;
  assign FetchAddr = r_pc;
  assign CurrentPC = r_pc;
  assign Retire    = r_retire;
  assign Halted    = r_halted;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected commit PCs go into a queue that a
// Retire-driven monitor drains; state/handshake checks are made inline.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        FetchReq;
  logic [63:0] FetchAddr;
  logic        FetchAck;
  logic        BrValid;
  logic        Branch;
  logic        Uncondbranch;
  logic        ALUZero;
  logic [63:0] SignExtImm64;
  logic        Stall;
  logic        Halt;
  logic [63:0] CurrentPC;
  logic        Retire;
  logic        Halted;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] RetireCnt;
  logic [31:0] TakenCnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];

  pc_sequencer dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .FetchReq     (FetchReq),
    .FetchAddr    (FetchAddr),
    .FetchAck     (FetchAck),
    .BrValid      (BrValid),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .SignExtImm64 (SignExtImm64),
    .Stall        (Stall),
    .Halt         (Halt),
    .CurrentPC    (CurrentPC),
    .Retire       (Retire),
    .Halted       (Halted)
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    .RetireCnt    (RetireCnt),
    .TakenCnt     (TakenCnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every Retire pulse must match the next queued commit PC.
  always @(negedge CLK) begin
    if (Retire === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", {8'h0, CurrentPC}, 72'h0);
      end else begin
        check("retire_pc", {8'h0, CurrentPC}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic clear_inputs();
    FetchAck = 0; BrValid = 0; Branch = 0; Uncondbranch = 0;
    ALUZero = 0; SignExtImm64 = '0; Stall = 0; Halt = 0;
  endtask

  task automatic wait_fetch(input logic [63:0] exp_addr, output int at_cyc);
    int n = 0;
    while (FetchReq !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    at_cyc = cyc;
    check("fetch_addr", {FetchReq, FetchAddr}, {1'b1, exp_addr});
  endtask

  task automatic do_fetch(input logic [63:0] exp_addr, input int ack_delay, input bit noise,
                          output int at_cyc);
    wait_fetch(exp_addr, at_cyc);
    for (int i = 0; i < ack_delay; i++) begin
      BrValid = noise & i[0]; Uncondbranch = noise; Halt = noise;
      @(posedge CLK); #1;
      check("fetch_hold", {FetchReq, FetchAddr}, {1'b1, exp_addr});
    end
    BrValid = 0; Uncondbranch = 0; Halt = 0; FetchAck = 1;
    @(posedge CLK); #1;
    FetchAck = 0;
    check("exec_entry_req", {71'h0, FetchReq}, 72'h0);
  endtask

  task automatic do_exec(input bit br, input bit ub, input bit z, input logic [63:0] imm,
                         input int stall_n, input bit halt,
                         input logic [63:0] pc_before, input logic [63:0] exp_pc);
    Branch = br; Uncondbranch = ub; ALUZero = z; SignExtImm64 = imm;
    BrValid = 1; Stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(posedge CLK); #1;
      check("stall_hold", {6'h0, Retire, FetchReq, CurrentPC}, {8'h0, pc_before});
    end
    Stall = 0; Halt = halt;
    exp_q.push_back(exp_pc);
    @(posedge CLK); #1;
    clear_inputs();
    check("halted_after_commit", {71'h0, Halted}, {71'h0, halt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c_dummy;
    Reset_L = 0;
    clear_inputs();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", {5'h0, FetchReq, Retire, Halted, CurrentPC}, 72'h0);
    Reset_L = 1;
    check("idle_no_req", {71'h0, FetchReq}, 72'h0);

    // Back-to-back sequential fetches from reset
    do_fetch(64'h0, 0, 0, c0);
    do_exec(0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h4);
    do_fetch(64'h4, 0, 0, c1);
    check("fetch_span_inclusive", 72'(c1 - c0 + 1), 72'd3);
    do_exec(0, 0, 0, 64'h0, 0, 0, 64'h4, 64'h8);
    do_fetch(64'h8, 0, 0, c_dummy);
    do_exec(0, 1, 0, 64'h3E, 0, 0, 64'h8, 64'h100);

    // Branch arithmetic around 0x100
    do_fetch(64'h100, 0, 0, c_dummy);
    do_exec(1, 0, 1, 64'd3, 0, 0, 64'h100, 64'h10C);
    do_fetch(64'h10C, 0, 0, c_dummy);
    do_exec(0, 1, 0, -64'd3, 0, 0, 64'h10C, 64'h100);
    do_fetch(64'h100, 0, 0, c_dummy);
    do_exec(1, 0, 0, 64'd3, 0, 0, 64'h100, 64'h104);
    do_fetch(64'h104, 0, 0, c_dummy);
    do_exec(0, 1, 1, -64'd1, 0, 0, 64'h104, 64'h100);
    do_fetch(64'h100, 0, 0, c_dummy);
    do_exec(0, 1, 0, -64'd2, 0, 0, 64'h100, 64'hF8);

    // Slow ack with BrValid/Halt noise in FETCH, then a 4-cycle stall
    do_fetch(64'hF8, 5, 1, c_dummy);
    do_exec(0, 0, 0, 64'h0, 4, 0, 64'hF8, 64'hFC);
    do_fetch(64'hFC, 0, 0, c_dummy);
    do_exec(0, 1, 0, -64'd55, 0, 0, 64'hFC, 64'h20);

    // Halt at commit
    do_fetch(64'h20, 0, 0, c_dummy);
    do_exec(0, 0, 0, 64'h0, 0, 1, 64'h20, 64'h24);
    for (int i = 0; i < 20; i++) begin
      FetchAck = i[0]; BrValid = ~i[0]; Uncondbranch = 1;
      @(posedge CLK); #1;
      check("halted_frozen", {6'h0, FetchReq, Halted, CurrentPC}, {8'h01, 64'h24});
    end
    clear_inputs();
`ifdef PC_SEQ_PERF_CNT_EN
    check("retire_cnt", {40'h0, RetireCnt}, 72'd11);
    check("taken_cnt", {40'h0, TakenCnt}, 72'd6);
`endif

    // Reset with a fetch of 0x40 outstanding; late ack must be ignored
    Reset_L = 0;
    @(posedge CLK); #1;
    Reset_L = 1;
    do_fetch(64'h0, 0, 0, c_dummy);
    do_exec(0, 1, 0, 64'h10, 0, 0, 64'h0, 64'h40);
    wait_fetch(64'h40, c_dummy);
    @(posedge CLK); #1;
    Reset_L = 0;
    @(posedge CLK); #1;
    check("reset_mid_fetch", {6'h0, FetchReq, Halted, CurrentPC}, 72'h0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("cnt_after_reset", {8'h0, RetireCnt, TakenCnt}, 72'h0);
`endif
    Reset_L = 1; FetchAck = 1;
    @(posedge CLK); #1;
    FetchAck = 0;
    check("late_ack_idle", {7'h0, FetchReq, CurrentPC}, {8'h01, 64'h0});
    @(posedge CLK); #1;
    check("late_ack_ignored", {7'h0, FetchReq, FetchAddr}, {8'h01, 64'h0});
    do_fetch(64'h0, 0, 0, c_dummy);
    do_exec(0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h4);
    repeat (2) @(posedge CLK);
    #1;
    check("queue_drained", 72'(exp_q.size()), 72'd0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("retire_cnt_final", {40'h0, RetireCnt}, 72'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_sequencer
